// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared state encoding and register table for the SPI config sequencer
package spi_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RELEASE,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] value;
  } cfg_entry_t;

  localparam cfg_entry_t CFG_TABLE [16] = '{
    '{6'h2C, 8'h0F},
    '{6'h31, 8'h0B},
    '{6'h38, 8'h00},
    '{6'h2D, 8'h08},
    '{6'h00, 8'h00}, '{6'h00, 8'h00}, '{6'h00, 8'h00}, '{6'h00, 8'h00},
    '{6'h00, 8'h00}, '{6'h00, 8'h00}, '{6'h00, 8'h00}, '{6'h00, 8'h00},
    '{6'h00, 8'h00}, '{6'h00, 8'h00}, '{6'h00, 8'h00}, '{6'h00, 8'h00}
  };

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK divider; idles high, first toggle CLK_DIV cycles after run rises
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sclk
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sclk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end else if (!run) begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end else if (r_cnt == DIV_LAST) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign sclk = r_sclk;

endmodule

// File: rtl/spi_config_sequencer.sv
// rtl/spi_config_sequencer.sv - walks CFG_TABLE and issues one SPI register write per entry
// Optional write timeout enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_config_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned NUM_REGS       = 4,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       wr_enable,
  output logic [5:0] wr_address,
  output logic [7:0] wr_value,
  input  logic       wr_complete,
  output logic       sclk,
  output logic       cs_n
);

  localparam int unsigned   GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]    IDX_LAST = 4'(NUM_REGS - 1);

  if (CLK_DIV < 2 || NUM_REGS < 1 || NUM_REGS > 16 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1)
  begin : g_bad_params
    $error("spi_config_sequencer: parameter out of range");
  end

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_index;
  logic [GW-1:0] r_gap_cnt;
  logic          w_run;
  logic          w_timeout;
  logic          w_gap_end;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (r_state != S_WRITE) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_WRITE) && (r_to_cnt == TO_LAST);
  assign error     = (r_state == S_ERROR);
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

  assign w_gap_end = (r_state == S_GAP) && (r_gap_cnt == GAP_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_LOAD;
      S_LOAD:                  w_next = S_WRITE;
      S_WRITE: begin
        if (wr_complete)    w_next = S_RELEASE;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_RELEASE:               if (!wr_complete) w_next = S_GAP;
      S_GAP: begin
        if (w_gap_end) w_next = (r_index == IDX_LAST) ? S_DONE : S_LOAD;
      end
      default:                 w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_index <= '0;
    end else if ((r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR) && start) begin
      r_index <= '0;
    end else if (w_gap_end && (r_index != IDX_LAST)) begin
      r_index <= r_index + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gap_cnt <= '0;
    end else if (r_state != S_GAP) begin
      r_gap_cnt <= '0;
    end else begin
      r_gap_cnt <= r_gap_cnt + 1'b1;
    end
  end

  // Drop run on the leaving edge so SCLK is forced high together with the state change.
  assign w_run = (r_state == S_WRITE) && (w_next == S_WRITE);

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk  (clk),
    .reset(reset),
    .run  (w_run),
    .sclk (sclk)
  );

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    wr_enable  = 1'b0;
    cs_n       = 1'b1;
    wr_address = '0;
    wr_value   = '0;
    case (r_state)
      S_LOAD: begin
        busy       = 1'b1;
        cs_n       = 1'b0;
        wr_address = CFG_TABLE[r_index].addr;
        wr_value   = CFG_TABLE[r_index].value;
      end
      S_WRITE: begin
        busy       = 1'b1;
        cs_n       = 1'b0;
        wr_enable  = 1'b1;
        wr_address = CFG_TABLE[r_index].addr;
        wr_value   = CFG_TABLE[r_index].value;
      end
      S_RELEASE, S_GAP: begin
        busy       = 1'b1;
        wr_address = CFG_TABLE[r_index].addr;
        wr_value   = CFG_TABLE[r_index].value;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_config_sequencer.sv
// tb/tb_spi_config_sequencer.sv - directed self-checking bench for spi_config_sequencer
module tb_spi_config_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic       error;
  logic       wr_enable;
  logic [5:0] wr_address;
  logic [7:0] wr_value;
  logic       wr_complete = 1'b0;
  logic       sclk;
  logic       cs_n;

  logic       never_complete;

  int n_cmp = 0;
  int n_err = 0;

  spi_config_sequencer #(
    .CLK_DIV(4),
    .NUM_REGS(4),
    .GAP_CYCLES(8),
    .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .wr_enable  (wr_enable),
    .wr_address (wr_address),
    .wr_value   (wr_value),
    .wr_complete(wr_complete),
    .sclk       (sclk),
    .cs_n       (cs_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int sclk_edges = 0;
  always @(sclk) sclk_edges++;

  logic [5:0] log_addr  [64];
  logic [7:0] log_val   [64];
  int         log_falls [64];
  int         wr_total  = 0;
  int         wr_starts = 0;
  int         cur_falls = 0;
  int         gap_run   = 0;
  int         gap_min   = 1000;
  int         sclk_viol = 0;
  int         err_seen  = 0;
  logic       prev_en   = 1'b0;
  logic       prev_sclk = 1'b1;

  // Behavioural shifter: completes after 16 falling SCLK edges, releases when enable drops.
  always @(negedge clk) begin
    if (wr_enable && !prev_en) begin
      log_addr[wr_total] = wr_address;
      log_val[wr_total]  = wr_value;
      cur_falls          = 0;
      wr_starts++;
    end
    if (wr_enable && prev_sclk && !sclk) cur_falls++;
    if (!wr_enable && prev_en) begin
      log_falls[wr_total] = cur_falls;
      wr_total++;
    end
    if (wr_enable) begin
      if (cur_falls == 16 && sclk && !never_complete) wr_complete = 1'b1;
    end else begin
      wr_complete = 1'b0;
    end
    if (busy && cs_n) begin
      gap_run++;
    end else begin
      if (!cs_n && gap_run != 0 && gap_run < gap_min) gap_min = gap_run;
      gap_run = 0;
    end
    if (cs_n && !sclk) sclk_viol++;
    if (error) err_seen++;
    prev_en   = wr_enable;
    prev_sclk = sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_starts(input int target, input string tag);
    int n = 0;
    while (wr_starts < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(wr_starts >= target), 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 1);
  endtask

  int base;
  int sbase;
  int edges_snap;
  int c0;
  int n;

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    never_complete = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_wr_enable", 32'(wr_enable), 0);
    check("rst_wr_address", 32'(wr_address), 0);
    check("rst_wr_value", 32'(wr_value), 0);
    check("rst_sclk", 32'(sclk), 1);
    check("rst_cs_n", 32'(cs_n), 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    // Basic sequence with an ignored start during the second write
    base  = wr_total;
    sbase = wr_starts;
    pulse_start();
    check("load_busy", 32'(busy), 1);
    check("load_cs_n", 32'(cs_n), 0);
    check("load_addr", 32'(wr_address), 32'h2C);
    wait_starts(sbase + 2, "second_write_reached");
    repeat (10) @(negedge clk);
    pulse_start();
    wait_done("basic_done_reached");
    check("basic_count", 32'(wr_total - base), 4);
    check("w0_addr", 32'(log_addr[base]), 32'h2C);
    check("w0_val", 32'(log_val[base]), 32'h0F);
    check("w1_addr", 32'(log_addr[base+1]), 32'h31);
    check("w1_val", 32'(log_val[base+1]), 32'h0B);
    check("w2_addr", 32'(log_addr[base+2]), 32'h38);
    check("w2_val", 32'(log_val[base+2]), 32'h00);
    check("w3_addr", 32'(log_addr[base+3]), 32'h2D);
    check("w3_val", 32'(log_val[base+3]), 32'h08);
    for (int i = 0; i < 4; i++) check($sformatf("w%0d_falls", i), 32'(log_falls[base+i]), 16);
    check("basic_done", 32'(done), 1);
    check("basic_busy", 32'(busy), 0);
    check("done_cs_n", 32'(cs_n), 1);
    check("done_addr_zero", 32'(wr_address), 0);
    check("gap_min_ge_8", 32'(gap_min >= 8), 1);
    check("gap_sclk_high", 32'(sclk_viol), 0);

    // Restart from DONE
    base = wr_total;
    pulse_start();
    check("restart_done_clr", 32'(done), 0);
    check("restart_busy", 32'(busy), 1);
    wait_done("restart_done_reached");
    check("restart_count", 32'(wr_total - base), 4);
    check("restart_first_addr", 32'(log_addr[base]), 32'h2C);
    check("restart_last_val", 32'(log_val[base+3]), 32'h08);

    // Reset abort during the third write, while SCLK is low
    sbase = wr_starts;
    pulse_start();
    wait_starts(sbase + 3, "third_write_reached");
    n = 0;
    while (sclk && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_sclk_low_seen", 32'(sclk), 0);
    #2 reset = 1'b1;
    #1;
    check("abort_sclk", 32'(sclk), 1);
    check("abort_cs_n", 32'(cs_n), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_wr_enable", 32'(wr_enable), 0);
    check("abort_wr_address", 32'(wr_address), 0);
    check("abort_wr_value", 32'(wr_value), 0);
    edges_snap = sclk_edges;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check("abort_no_sclk_edges", 32'(sclk_edges - edges_snap), 0);
    check("abort_stays_idle", 32'(busy), 0);
    check("abort_no_new_write", 32'(wr_starts - sbase), 3);

`ifdef SPI_SEQ_TIMEOUT_EN
    never_complete = 1'b1;
    pulse_start();
    n = 0;
    while (!wr_enable && n < 50) begin
      @(negedge clk);
      n++;
    end
    c0 = cyc;
    n  = 0;
    while (!error && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("to_error", 32'(error), 1);
    check("to_latency", 32'(cyc - c0), 4096);
    check("to_cs_n", 32'(cs_n), 1);
    check("to_wr_enable", 32'(wr_enable), 0);
    check("to_sclk", 32'(sclk), 1);
    check("to_busy", 32'(busy), 0);
    never_complete = 1'b0;
    pulse_start();
    check("to_restart_err_clr", 32'(error), 0);
    check("to_restart_addr", 32'(wr_address), 32'h2C);
    wait_done("to_restart_done_reached");
`else
    check("error_never_seen", 32'(err_seen), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
